ultrasonic_ranger: RTL and testbench

- HC-SR04 ranging controller; drives `trig`, times `echo`, and converts the echo width to centimetres.
- Produces `sens_ult`, the proximity flag consumed by the tamagotchi FSM as the "diversion" input, plus a distance bus for display and debug.
- Sits directly upstream of the FSM, in parallel with the button conditioner and the MPU6050 path.

---
 rtl/ult_pkg.sv | 19 +
 rtl/ult_proximity.sv | 83 ++++++++
 rtl/ultrasonic_ranger.sv | 185 ++++++++++++++++++
 tb/tb_ultrasonic_ranger.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ult_pkg.sv
// ult_pkg: shared definitions for the HC-SR04 ultrasonic ranger.
//   ult_state_t : ranging FSM states
//   DIST_W      : width of the distance bus in centimetres
//   DIST_MAX    : saturation value, also reported on timeout
package ult_pkg;

    localparam int DIST_W = 9;
    localparam logic [DIST_W-1:0] DIST_MAX = 9'd511;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        DONE,
        TOUT
    } ult_state_t;

endpackage

// File: rtl/ult_proximity.sv
// ult_proximity: turns distance readings into the near/far proximity flag.
//   clk, rst : system clock, synchronous active-high reset
//   upd      : one-cycle strobe, distance holds a fresh reading
//   distance : reading in centimetres (DIST_MAX means nothing in range)
//   near     : registered proximity flag
// near sets at or below NEAR_CM and clears only above NEAR_CM+HYST_CM;
// readings inside the band leave it unchanged.
// Build option ULT_HIT_FILTER_EN: near sets only after HITS consecutive near
// readings and clears only after HITS consecutive far readings; a band
// reading restarts both runs. Without the macro every reading acts alone.
module ult_proximity
    import ult_pkg::*;
#(
    parameter int NEAR_CM = 10,
    parameter int HYST_CM = 2,
    parameter int HITS    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              upd,
    input  logic [DIST_W-1:0] distance,
    output logic              near
);

    localparam logic [31:0] NEAR_LIM = 32'(NEAR_CM);
    localparam logic [31:0] FAR_LIM  = 32'(NEAR_CM + HYST_CM);

`ifdef ULT_HIT_FILTER_EN
    localparam bit FILTER_BUILD = 1'b1;
`else
    localparam bit FILTER_BUILD = 1'b0;
`endif
    // A filter of one hit is exactly the single-reading rule, so the run
    // counters only exist when they can change behaviour.
    localparam bit USE_FILTER = FILTER_BUILD && (HITS > 1);

    logic is_near;
    logic is_far;

    assign is_near = (32'(distance) <= NEAR_LIM);
    assign is_far  = (32'(distance) >  FAR_LIM);

    if (USE_FILTER) begin : g_filter
        localparam int RUN_W = $clog2(HITS + 1);
        localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(HITS);
        localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(HITS - 1);

        logic [RUN_W-1:0] near_run;
        logic [RUN_W-1:0] far_run;

        always_ff @(posedge clk) begin
            if (rst) begin
                near_run <= '0;
                far_run  <= '0;
                near     <= 1'b0;
            end else if (upd) begin
                if (is_near) begin
                    far_run <= '0;
                    if (near_run != RUN_MAX) near_run <= near_run + RUN_W'(1);
                    // this reading completes the run of HITS
                    if (near_run >= RUN_LAST) near <= 1'b1;
                end else if (is_far) begin
                    near_run <= '0;
                    if (far_run != RUN_MAX) far_run <= far_run + RUN_W'(1);
                    if (far_run >= RUN_LAST) near <= 1'b0;
                end else begin
                    near_run <= '0;
                    far_run  <= '0;
                end
            end
        end
    end else begin : g_single
        always_ff @(posedge clk) begin
            if (rst) begin
                near <= 1'b0;
            end else if (upd) begin
                if (is_near)     near <= 1'b1;
                else if (is_far) near <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ultrasonic_ranger.sv
// ultrasonic_ranger: HC-SR04 controller. Fires trig once per period, times
// the echo pulse and reports the distance in centimetres plus a proximity
// flag for the tamagotchi FSM.
//   clk, rst    : system clock, synchronous active-high reset
//   echo        : sensor echo, asynchronous to clk
//   trig        : trigger pulse, high for TRIG_CYCLES
//   distance_cm : last reading, saturates at 511, 511 after a timeout
//   dist_valid  : one-cycle strobe, distance_cm was just updated
//   timeout_o   : one-cycle strobe alongside dist_valid when no valid echo
//   sens_ult    : proximity flag (hysteresis in ult_proximity)
//   led1        : copy of sens_ult
// Build option ULT_HIT_FILTER_EN enables the consecutive-hit filter inside
// ult_proximity.
// Result strobe: dist_valid is a pure one-cycle strobe with no ready/back-
// pressure; distance_cm and timeout_o are valid in that cycle and
// distance_cm then holds until the next strobe. The FSM state is kept in the
// named signal 'state' for observation.
module ultrasonic_ranger
    import ult_pkg::*;
#(
    parameter int TRIG_CYCLES    = 500,
    parameter int CYC_PER_CM     = 2900,
    parameter int PERIOD_CYCLES  = 3_000_000,
    parameter int TIMEOUT_CYCLES = 1_500_000,
    parameter int NEAR_CM        = 10,
    parameter int HYST_CM        = 2,
    parameter int HITS           = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              echo,
    output logic              trig,
    output logic [DIST_W-1:0] distance_cm,
    output logic              dist_valid,
    output logic              timeout_o,
    output logic              sens_ult,
    output logic              led1
);

    localparam int PER_W   = $clog2(PERIOD_CYCLES);
    localparam int TMR_MAX = (TRIG_CYCLES > TIMEOUT_CYCLES) ? TRIG_CYCLES : TIMEOUT_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int SUB_W   = (CYC_PER_CM > 1) ? $clog2(CYC_PER_CM) : 1;

    localparam logic [PER_W-1:0] PER_LAST  = PER_W'(PERIOD_CYCLES - 1);
    localparam logic [TMR_W-1:0] TRIG_LAST = TMR_W'(TRIG_CYCLES - 1);
    localparam logic [TMR_W-1:0] TOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TOUT_LIM  = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(CYC_PER_CM - 1);

    ult_state_t        state;
    logic              echo_m;
    logic              echo_s;
    logic [PER_W-1:0]  period_cnt;
    logic              start;
    logic [TMR_W-1:0]  tmr;
    logic [SUB_W-1:0]  sub_cnt;
    logic [DIST_W-1:0] cm_cnt;
    logic [SUB_W-1:0]  sub_base;
    logic [DIST_W-1:0] cm_base;
    logic [SUB_W-1:0]  sub_next;
    logic [DIST_W-1:0] cm_next;
    logic              prox_near;

    // Two-flop synchroniser for the asynchronous echo
    always_ff @(posedge clk) begin
        if (rst) begin
            echo_m <= 1'b0;
            echo_s <= 1'b0;
        end else begin
            echo_m <= echo;
            echo_s <= echo_m;
        end
    end

    // Free-running period counter; start pulses on the wrap
    always_ff @(posedge clk) begin
        if (rst)                     period_cnt <= '0;
        else if (period_cnt == PER_LAST) period_cnt <= '0;
        else                         period_cnt <= period_cnt + PER_W'(1);
    end

    assign start = (period_cnt == PER_LAST);

    // One echo-high sample advances the cm timebase. The sample that moves
    // WAIT_RISE into MEASURE counts too, so an echo of N cycles gives
    // floor(N / CYC_PER_CM) cm.
    always_comb begin
        sub_base = (state == MEASURE) ? sub_cnt : '0;
        cm_base  = (state == MEASURE) ? cm_cnt  : '0;
        sub_next = sub_base + SUB_W'(1);
        cm_next  = cm_base;
        if (sub_base == SUB_LAST) begin
            sub_next = '0;
            if (cm_base != DIST_MAX) cm_next = cm_base + DIST_W'(1);
        end
    end

    // tmr: trigger width in TRIG, rise wait in WAIT_RISE, echo width in MEASURE
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            trig        <= 1'b0;
            distance_cm <= DIST_MAX;
            dist_valid  <= 1'b0;
            timeout_o   <= 1'b0;
            tmr         <= '0;
            sub_cnt     <= '0;
            cm_cnt      <= '0;
        end else begin
            dist_valid <= 1'b0;
            timeout_o  <= 1'b0;
            case (state)
                IDLE: begin
                    // a start seen in any other state is simply dropped
                    if (start) begin
                        state <= TRIG;
                        trig  <= 1'b1;
                        tmr   <= '0;
                    end
                end
                TRIG: begin
                    if (tmr == TRIG_LAST) begin
                        state <= WAIT_RISE;
                        trig  <= 1'b0;
                        tmr   <= '0;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                WAIT_RISE: begin
                    if (echo_s) begin
                        state   <= MEASURE;
                        sub_cnt <= sub_next;
                        cm_cnt  <= cm_next;
                        tmr     <= TMR_W'(1);
                    end else if (tmr == TOUT_LAST) begin
                        state       <= TOUT;
                        distance_cm <= DIST_MAX;
                        dist_valid  <= 1'b1;
                        timeout_o   <= 1'b1;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                MEASURE: begin
                    if (!echo_s) begin
                        state       <= DONE;
                        distance_cm <= cm_cnt;
                        dist_valid  <= 1'b1;
                    end else if (tmr == TOUT_LIM) begin
                        state       <= TOUT;
                        distance_cm <= DIST_MAX;
                        dist_valid  <= 1'b1;
                        timeout_o   <= 1'b1;
                    end else begin
                        sub_cnt <= sub_next;
                        cm_cnt  <= cm_next;
                        tmr     <= tmr + TMR_W'(1);
                    end
                end
                DONE:    state <= IDLE;
                TOUT:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // dist_valid is high during DONE/TOUT, so sens_ult moves the cycle after
    ult_proximity #(
        .NEAR_CM (NEAR_CM),
        .HYST_CM (HYST_CM),
        .HITS    (HITS)
    ) u_proximity (
        .clk      (clk),
        .rst      (rst),
        .upd      (dist_valid),
        .distance (distance_cm),
        .near     (prox_near)
    );

    assign sens_ult = prox_near;
    assign led1     = prox_near;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
`timescale 1ns/1ps
module tb_ultrasonic_ranger;

    localparam int P      = 200;
    localparam int TRIG_C = 5;
    localparam int CPC    = 4;
    localparam int TO     = 100;
    localparam int NEAR   = 10;
    localparam int HYST   = 2;
    localparam int HITS   = 3;

    // ---------------- clock / reset ----------------
    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       echo = 1'b0;
    logic       trig;
    logic [8:0] distance_cm;
    logic       dist_valid;
    logic       timeout_o;
    logic       sens_ult;
    logic       led1;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    // cycles since the last reset edge; the first trigger is due at cyc == P
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    ultrasonic_ranger #(
        .TRIG_CYCLES    (TRIG_C),
        .CYC_PER_CM     (CPC),
        .PERIOD_CYCLES  (P),
        .TIMEOUT_CYCLES (TO),
        .NEAR_CM        (NEAR),
        .HYST_CM        (HYST),
        .HITS           (HITS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .echo        (echo),
        .trig        (trig),
        .distance_cm (distance_cm),
        .dist_valid  (dist_valid),
        .timeout_o   (timeout_o),
        .sens_ult    (sens_ult),
        .led1        (led1)
    );

    // ---------------- reference model ----------------
    logic [8:0] exp_q[$];
    bit m_near = 1'b0;
    int m_nrun = 0;
    int m_frun = 0;

    function automatic int exp_dist(input int width);
        if (width == 0 || width > TO) return 511;
        if (width / CPC > 511) return 511;
        return width / CPC;
    endfunction

    task automatic model_reset();
        m_near = 1'b0;
        m_nrun = 0;
        m_frun = 0;
    endtask

    task automatic model_update(input int d);
        if (d <= NEAR) begin
`ifdef ULT_HIT_FILTER_EN
            m_frun = 0;
            if (m_nrun < HITS) m_nrun++;
            if (m_nrun >= HITS) m_near = 1'b1;
`else
            m_near = 1'b1;
`endif
        end else if (d > NEAR + HYST) begin
`ifdef ULT_HIT_FILTER_EN
            m_nrun = 0;
            if (m_frun < HITS) m_frun++;
            if (m_frun >= HITS) m_near = 1'b0;
`else
            m_near = 1'b0;
`endif
        end else begin
            m_nrun = 0;
            m_frun = 0;
        end
    endtask

    // ---------------- driver ----------------
    int o_rise, o_tlen, o_lat, o_dist, o_vlen;
    bit o_to, o_sb, o_sa, o_led;

    // Waits for the next trigger, then drives an echo of 'width' cycles
    // starting 'gap' cycles after trig falls (width 0: no echo), and records
    // what the DUT reports. t counts negedges after the trig-falling edge.
    task automatic measure(input int width, input int gap);
        int t;
        int vt;
        bit seen;
        o_rise = -1; o_tlen = 0; o_lat = -1; o_dist = -1; o_vlen = 0;
        o_to = 1'b0; o_sb = 1'b0; o_sa = 1'b0; o_led = 1'b0;
        t = 0;
        while (trig !== 1'b1 && t < 2 * P + 10) begin
            @(negedge clk);
            t++;
        end
        if (trig !== 1'b1) return;
        o_rise = cyc;
        while (trig === 1'b1 && o_tlen < 4 * TRIG_C) begin
            o_tlen++;
            @(negedge clk);
        end
        seen = 1'b0;
        vt = 0;
        for (t = 0; t < P - 10; t++) begin
            if (dist_valid === 1'b1) begin
                o_vlen++;
                if (!seen) begin
                    seen   = 1'b1;
                    vt     = t;
                    o_lat  = t;
                    o_dist = int'(distance_cm);
                    o_to   = timeout_o;
                    o_sb   = sens_ult;
                end
            end
            if (seen && t == vt + 1) begin
                o_sa  = sens_ult;
                o_led = led1;
            end
            if (seen && t > vt + 2 && t >= gap + width) break;
            echo = (width > 0 && t >= gap && t < gap + width);
            @(negedge clk);
        end
        echo = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int bad;
        rst = 1'b1;
        echo = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        n_checks++;
        if ({trig, dist_valid, timeout_o, sens_ult, led1} !== 5'b0 || distance_cm !== 9'd511) begin
            n_errors++;
            $display("FAIL reset_values: trig=%b dv=%b to=%b sens=%b led=%b dist=%0d, need zeros and dist 511",
                     trig, dist_valid, timeout_o, sens_ult, led1, distance_cm);
        end
        rst = 1'b0;
        bad = 0;
        while (cyc < P - 1) begin
            @(negedge clk);
            if (trig !== 1'b0 || distance_cm !== 9'd511 || dist_valid !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL idle_before_first_trigger: %0d bad cycles, need 0", bad);
        end
    endtask

    task automatic test_first_echo();
        bit prior;
        prior = m_near;
        measure(40, $urandom_range(0, 3));
        n_checks++;
        if (o_rise !== P) begin n_errors++; $display("FAIL first_trig_cycle: got %0d need %0d", o_rise, P); end
        n_checks++;
        if (o_tlen !== TRIG_C) begin n_errors++; $display("FAIL trig_width: got %0d need %0d", o_tlen, TRIG_C); end
        n_checks++;
        if (o_dist !== exp_dist(40)) begin n_errors++; $display("FAIL echo40_dist: got %0d need %0d", o_dist, exp_dist(40)); end
        n_checks++;
        if (o_to !== 1'b0 || o_vlen !== 1) begin n_errors++; $display("FAIL echo40_strobes: to=%b valid_len=%0d need 0 and 1", o_to, o_vlen); end
        n_checks++;
        if (o_sb !== prior) begin n_errors++; $display("FAIL echo40_sens_early: got %b need %b", o_sb, prior); end
        model_update(exp_dist(40));
        n_checks++;
        if (o_sa !== m_near || o_led !== m_near) begin
            n_errors++;
            $display("FAIL echo40_sens: sens=%b led=%b need %b", o_sa, o_led, m_near);
        end
    endtask

    task automatic test_hysteresis();
        int widths[3] = '{48, 52, 60};
        int prev_rise;
        bit prior;
        prev_rise = o_rise;
        foreach (widths[i]) begin
            prior = m_near;
            measure(widths[i], $urandom_range(0, 4));
            n_checks++;
            if (o_dist !== exp_dist(widths[i])) begin
                n_errors++;
                $display("FAIL hyst_dist w=%0d: got %0d need %0d", widths[i], o_dist, exp_dist(widths[i]));
            end
            n_checks++;
            if (o_rise !== prev_rise + P) begin
                n_errors++;
                $display("FAIL hyst_period w=%0d: rise %0d need %0d", widths[i], o_rise, prev_rise + P);
            end
            prev_rise = o_rise;
            n_checks++;
            if (o_sb !== prior) begin n_errors++; $display("FAIL hyst_sens_early w=%0d: got %b need %b", widths[i], o_sb, prior); end
            model_update(exp_dist(widths[i]));
            n_checks++;
            if (o_sa !== m_near || o_led !== m_near) begin
                n_errors++;
                $display("FAIL hyst_sens w=%0d: sens=%b led=%b need %b", widths[i], o_sa, o_led, m_near);
            end
        end
    endtask

    task automatic test_no_echo();
        measure(0, 0);
        n_checks++;
        if (o_lat !== TO) begin n_errors++; $display("FAIL noecho_latency: got %0d need %0d", o_lat, TO); end
        n_checks++;
        if (o_to !== 1'b1 || o_vlen !== 1) begin n_errors++; $display("FAIL noecho_strobes: to=%b valid_len=%0d need 1 and 1", o_to, o_vlen); end
        n_checks++;
        if (o_dist !== 511) begin n_errors++; $display("FAIL noecho_dist: got %0d need 511", o_dist); end
        model_update(511);
        n_checks++;
        if (o_sa !== m_near) begin n_errors++; $display("FAIL noecho_sens: got %b need %b", o_sa, m_near); end
    endtask

    task automatic test_measure_timeout();
        int r;
        measure(150, $urandom_range(0, 3));
        r = o_rise;
        n_checks++;
        if (o_to !== 1'b1 || o_dist !== 511) begin
            n_errors++;
            $display("FAIL meas_timeout: to=%b dist=%0d need 1 and 511", o_to, o_dist);
        end
        model_update(511);
        n_checks++;
        if (o_sa !== m_near) begin n_errors++; $display("FAIL meas_timeout_sens: got %b need %b", o_sa, m_near); end
        measure(21, 2);
        n_checks++;
        if (o_rise !== r + P) begin n_errors++; $display("FAIL after_timeout_period: rise %0d need %0d", o_rise, r + P); end
        n_checks++;
        if (o_dist !== exp_dist(21) || o_to !== 1'b0) begin
            n_errors++;
            $display("FAIL after_timeout_dist: got %0d to=%b need %0d to=0", o_dist, o_to, exp_dist(21));
        end
        model_update(exp_dist(21));
    endtask

    task automatic test_random();
        int w;
        int prev_rise;
        bit prior;
        logic [8:0] exp_v;
        prev_rise = o_rise;
        for (int i = 0; i < 8; i++) begin
            w = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 90));
            exp_q.push_back(9'(exp_dist(w)));
            prior = m_near;
            measure(w, $urandom_range(0, 5));
            exp_v = exp_q.pop_front();
            n_checks++;
            if (o_dist !== int'(exp_v)) begin n_errors++; $display("FAIL rand_dist w=%0d: got %0d need %0d", w, o_dist, exp_v); end
            n_checks++;
            if (o_to !== (w == 0)) begin n_errors++; $display("FAIL rand_timeout w=%0d: got %b need %b", w, o_to, (w == 0)); end
            n_checks++;
            if (o_rise !== prev_rise + P) begin n_errors++; $display("FAIL rand_period: rise %0d need %0d", o_rise, prev_rise + P); end
            prev_rise = o_rise;
            n_checks++;
            if (o_sb !== prior) begin n_errors++; $display("FAIL rand_sens_early w=%0d: got %b need %b", w, o_sb, prior); end
            model_update(int'(exp_v));
            n_checks++;
            if (o_sa !== m_near || o_led !== m_near) begin
                n_errors++;
                $display("FAIL rand_sens w=%0d: sens=%b led=%b need %b", w, o_sa, o_led, m_near);
            end
        end
    endtask

    // three far readings, then 5,5,20,5,5,5 cm
    task automatic test_filter_sequence();
        int cms[9] = '{511, 511, 511, 5, 5, 20, 5, 5, 5};
        int w;
        foreach (cms[i]) begin
            w = (cms[i] == 511) ? 0 : cms[i] * CPC + int'($urandom_range(0, CPC - 1));
            measure(w, $urandom_range(0, 3));
            n_checks++;
            if (o_dist !== cms[i]) begin n_errors++; $display("FAIL seq_dist #%0d: got %0d need %0d", i, o_dist, cms[i]); end
            model_update(cms[i]);
            n_checks++;
            if (o_sa !== m_near) begin n_errors++; $display("FAIL seq_sens #%0d: got %b need %b", i, o_sa, m_near); end
        end
    endtask

    task automatic test_reset_mid_measure();
        int t;
        t = 0;
        while (trig !== 1'b1 && t < 2 * P + 10) begin @(negedge clk); t++; end
        t = 0;
        while (trig === 1'b1 && t < 4 * TRIG_C) begin @(negedge clk); t++; end
        echo = 1'b1;
        repeat (20) @(negedge clk);
        n_checks++;
        if (distance_cm !== 9'd5 || sens_ult !== m_near) begin
            n_errors++;
            $display("FAIL pre_reset_state: dist=%0d sens=%b need 5 and %b", distance_cm, sens_ult, m_near);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({trig, dist_valid, timeout_o, sens_ult, led1} !== 5'b0 || distance_cm !== 9'd511) begin
            n_errors++;
            $display("FAIL mid_reset_values: trig=%b dv=%b to=%b sens=%b led=%b dist=%0d, need zeros and dist 511",
                     trig, dist_valid, timeout_o, sens_ult, led1, distance_cm);
        end
        echo = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        measure(28, 1);
        n_checks++;
        if (o_rise !== P) begin n_errors++; $display("FAIL post_reset_trig_cycle: got %0d need %0d", o_rise, P); end
        n_checks++;
        if (o_dist !== exp_dist(28)) begin n_errors++; $display("FAIL post_reset_dist: got %0d need %0d", o_dist, exp_dist(28)); end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        test_reset();
        test_first_echo();
        test_hysteresis();
        test_no_echo();
        test_measure_timeout();
        test_random();
        test_filter_sequence();
        test_reset_mid_measure();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

endmodule
